// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data request and response channels plus the memory port
// shared by the arbiter (slave) and the core/memory side (master).
interface mem_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic        i_rready;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic        d_wr;
    logic [1:0]  d_sz;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic        d_rready;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [1:0]  mem_sz;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_valid, i_addr, i_rready,
        input  d_valid, d_addr, d_wr, d_sz, d_wdata, d_rready,
        input  mem_rdata,
        output i_ready, i_rvalid, i_rdata, i_err,
        output d_ready, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_wdata, mem_wr, mem_sz
    );

    modport master (
        output i_valid, i_addr, i_rready,
        output d_valid, d_addr, d_wr, d_sz, d_wdata, d_rready,
        output mem_rdata,
        input  i_ready, i_rvalid, i_rdata, i_err,
        input  d_ready, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_wdata, mem_wr, mem_sz
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter sequencing one access at a time onto a
// single-port byte-lane memory: IDLE accept, one ACCESS cycle, held RESP.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  starve_cnt;
    logic        owner_d;
    logic        wr_r;
    logic        rvalid_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic        starved;
    logic        grant_i;
    logic        grant_d;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_sz;
    logic        req_wr;
    logic        req_bad;
    logic        resp_taken;

    assign starved = bus.i_valid && (starve_cnt == 4'(STARVE_MAX));
    assign grant_i = (state == IDLE) && bus.i_valid && (!bus.d_valid || starved);
    assign grant_d = (state == IDLE) && bus.d_valid && !starved;

    assign bus.i_ready = grant_i;
    assign bus.d_ready = grant_d;

    // Fetches are always aligned-word reads; only the data port carries size/wr.
    assign req_addr  = grant_d ? bus.d_addr : bus.i_addr;
    assign req_sz    = grant_d ? bus.d_sz : 2'b10;
    assign req_wr    = grant_d && bus.d_wr;
    assign req_wdata = grant_d ? bus.d_wdata : 32'h0;
    assign req_bad   = (req_sz == 2'b11) ||
                       ((req_sz == 2'b01) && req_addr[0]) ||
                       ((req_sz == 2'b10) && (req_addr[1:0] != 2'b00));

    assign resp_taken = owner_d ? bus.d_rready : bus.i_rready;

    assign bus.i_rvalid = rvalid_r && !owner_d;
    assign bus.d_rvalid = rvalid_r && owner_d;
    assign bus.i_rdata  = rdata_r;
    assign bus.d_rdata  = rdata_r;
    assign bus.i_err    = err_r && bus.i_rvalid;
    assign bus.d_err    = err_r && bus.d_rvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            starve_cnt    <= 4'd0;
            owner_d       <= 1'b0;
            wr_r          <= 1'b0;
            rvalid_r      <= 1'b0;
            err_r         <= 1'b0;
            rdata_r       <= 32'h0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_wr    <= 1'b0;
            bus.mem_sz    <= 2'b10;
        end else begin
            if (!bus.i_valid || grant_i)
                starve_cnt <= 4'd0;
            else if (grant_d && (starve_cnt != 4'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        owner_d <= grant_d;
                        err_r   <= req_bad;
                        if (req_bad) begin
                            // Rejected requests never touch the memory port.
                            rvalid_r <= 1'b1;
                            rdata_r  <= 32'h0;
                            state    <= RESP;
                        end else begin
                            bus.mem_addr  <= req_addr;
                            bus.mem_sz    <= req_sz;
                            bus.mem_wdata <= req_wdata;
                            bus.mem_wr    <= req_wr;
                            wr_r          <= req_wr;
                            state         <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    bus.mem_wr <= 1'b0;
                    rdata_r    <= wr_r ? 32'h0 : bus.mem_rdata;
                    rvalid_r   <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_taken) begin
                        rvalid_r <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte-lane memory model behind it.
module tb_mem_arbiter;
    typedef struct packed {
        logic        d;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ma;
    assign ma = bus.mem_addr[7:0];

    always_comb begin
        bus.mem_rdata = 32'h0;
        case (bus.mem_sz)
            2'b00:   bus.mem_rdata = {24'h0, mem[ma]};
            2'b01:   bus.mem_rdata = {16'h0, mem[8'(ma + 8'd1)], mem[ma]};
            default: bus.mem_rdata = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)],
                                      mem[8'(ma + 8'd1)], mem[ma]};
        endcase
    end

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 8'hEF; mem[8'h11] <= 8'hBE;
            mem[8'h12] <= 8'hAD; mem[8'h13] <= 8'hDE;
        end else if (bus.mem_wr) begin
            mem[ma] <= bus.mem_wdata[7:0];
            if (bus.mem_sz != 2'b00) mem[8'(ma + 8'd1)] <= bus.mem_wdata[15:8];
            if (bus.mem_sz == 2'b10) begin
                mem[8'(ma + 8'd2)] <= bus.mem_wdata[23:16];
                mem[8'(ma + 8'd3)] <= bus.mem_wdata[31:24];
            end
        end
    end

    int tests = 0;
    int fails = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Expected response of whatever request the stimulus is currently presenting.
    logic [31:0] exp_i_data = 32'h0, exp_d_data = 32'h0;
    logic        exp_i_err = 1'b0, exp_d_err = 1'b0;

    resp_t       sb[$];
    logic        glog[$];
    int          wr_cnt = 0;
    logic [31:0] last_waddr = 32'h0, last_wdata = 32'h0;
    logic [1:0]  last_wsz = 2'b00;

    always @(negedge clk) begin
        resp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.i_valid && bus.i_ready) begin
                sb.push_back('{d: 1'b0, data: exp_i_data, err: exp_i_err});
                glog.push_back(1'b0);
            end
            if (bus.d_valid && bus.d_ready) begin
                sb.push_back('{d: 1'b1, data: exp_d_data, err: exp_d_err});
                glog.push_back(1'b1);
            end
            if (bus.mem_wr) begin
                wr_cnt++;
                last_waddr = bus.mem_addr;
                last_wdata = bus.mem_wdata;
                last_wsz   = bus.mem_sz;
            end
            if (bus.i_rvalid && bus.d_rvalid) chk("both_rvalid", 32'd1, 32'd0);
            if ((bus.i_rvalid && bus.i_rready) || (bus.d_rvalid && bus.d_rready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.d) begin
                        chk("resp_port_d", {31'h0, bus.d_rvalid}, 32'd1);
                        chk("d_rdata", bus.d_rdata, e.data);
                        chk("d_err", {31'h0, bus.d_err}, {31'h0, e.err});
                    end else begin
                        chk("resp_port_i", {31'h0, bus.i_rvalid}, 32'd1);
                        chk("i_rdata", bus.i_rdata, e.data);
                        chk("i_err", {31'h0, bus.i_err}, {31'h0, e.err});
                    end
                end
            end
        end
    end

    task automatic req(input bit d, input logic [31:0] addr, input bit wr,
                       input logic [1:0] sz, input logic [31:0] wdata,
                       input logic [31:0] edata, input bit eerr, input int elat,
                       output int wc);
        int lat;
        if (d) begin
            exp_d_data = edata; exp_d_err = eerr;
            bus.d_addr = addr; bus.d_wr = wr; bus.d_sz = sz; bus.d_wdata = wdata;
            bus.d_valid = 1'b1;
        end else begin
            exp_i_data = edata; exp_i_err = eerr;
            bus.i_addr = addr;
            bus.i_valid = 1'b1;
        end
        wc = 0;
        do begin @(negedge clk); wc++; end
        while (!(d ? bus.d_ready : bus.i_ready) && wc < 20);
        chk("req_accept", {31'h0, (d ? bus.d_ready : bus.i_ready)}, 32'd1);
        @(posedge clk); #1;
        if (d) bus.d_valid = 1'b0; else bus.i_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end
        while (!(d ? bus.d_rvalid : bus.i_rvalid) && lat < 10);
        chk("resp_latency", 32'(lat), 32'(elat));
        @(posedge clk); #1;
    endtask

    initial begin
        int wc, w0, g0, n;
        logic [9:0] order;
        bus.i_valid = 0; bus.i_addr = 0; bus.i_rready = 1;
        bus.d_valid = 0; bus.d_addr = 0; bus.d_wr = 0; bus.d_sz = 0;
        bus.d_wdata = 0; bus.d_rready = 1;

        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        chk("rst_i_ready", {31'h0, bus.i_ready}, 32'd0);
        chk("rst_d_ready", {31'h0, bus.d_ready}, 32'd0);
        chk("rst_i_rvalid", {31'h0, bus.i_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'h0, bus.d_rvalid}, 32'd0);
        chk("rst_errs", {30'h0, bus.i_err, bus.d_err}, 32'd0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        chk("rst_mem_wr", {31'h0, bus.mem_wr}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_sz", {30'h0, bus.mem_sz}, 32'h2);
        @(posedge clk); #1 rst_n = 1'b1;

        // Fetch: ready in the first cycle, response two cycles later.
        w0 = wr_cnt;
        req(0, 32'h10, 0, 2'b10, 0, 32'hDEADBEEF, 0, 2, wc);
        chk("fetch_ready_cycle", 32'(wc), 32'd1);
        chk("fetch_no_write", 32'(wr_cnt - w0), 32'd0);

        // Half store, then read back.
        w0 = wr_cnt;
        req(1, 32'h22, 1, 2'b01, 32'h1234, 32'h0, 0, 2, wc);
        chk("store_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("store_addr", last_waddr, 32'h22);
        chk("store_sz", {30'h0, last_wsz}, 32'h1);
        req(1, 32'h22, 0, 2'b01, 0, 32'h1234, 0, 2, wc);
        req(1, 32'h23, 0, 2'b00, 0, 32'h12, 0, 2, wc);

        // Print MMIO word store.
        req(1, 32'h80000000, 1, 2'b10, 32'h41, 32'h0, 0, 2, wc);
        chk("mmio_addr", last_waddr, 32'h80000000);
        chk("mmio_wdata", last_wdata, 32'h41);

        // Misaligned/illegal: error one cycle after accept, memory untouched.
        w0 = wr_cnt;
        req(1, 32'h6, 1, 2'b10, 32'h11, 32'h0, 1, 1, wc);
        req(1, 32'h3, 1, 2'b01, 32'h22, 32'h0, 1, 1, wc);
        req(1, 32'h8, 1, 2'b11, 32'h33, 32'h0, 1, 1, wc);
        req(0, 32'h12, 0, 2'b10, 0, 32'h0, 1, 1, wc);
        chk("err_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("err_mem_addr_held", bus.mem_addr, 32'h80000000);

        // Starvation: both held high.
        g0 = glog.size();
        exp_i_data = 32'hDEADBEEF; exp_i_err = 0;
        exp_d_data = 32'h12340000; exp_d_err = 0;
        bus.i_addr = 32'h10;
        bus.d_addr = 32'h20; bus.d_wr = 0; bus.d_sz = 2'b10;
        bus.i_valid = 1; bus.d_valid = 1;
        n = 0;
        do begin @(posedge clk); n++; end while ((glog.size() - g0) < 10 && n < 100);
        #1 bus.i_valid = 0; bus.d_valid = 0;
        chk("starve_grants", 32'(glog.size() - g0), 32'd10);
        order = 10'b1111011110;
        for (int k = 0; k < 10; k++)
            if (g0 + k < glog.size())
                chk($sformatf("starve_grant%0d", k), {31'h0, glog[g0 + k]}, {31'h0, order[9 - k]});
        n = 0;
        do begin @(negedge clk); n++; end
        while ((sb.size() != 0 || bus.i_rvalid || bus.d_rvalid) && n < 20);
        chk("starve_drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        // Backpressure on D response while I waits.
        bus.d_rready = 0;
        exp_d_data = 32'h1234; exp_d_err = 0;
        bus.d_addr = 32'h22; bus.d_wr = 0; bus.d_sz = 2'b01; bus.d_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_ready && n < 20);
        @(posedge clk); #1 bus.d_valid = 0;
        exp_i_data = 32'hDEADBEEF; exp_i_err = 0;
        bus.i_addr = 32'h10; bus.i_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_rvalid && n < 20);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rvalid", {31'h0, bus.d_rvalid}, 32'd1);
            chk("bp_rdata", bus.d_rdata, 32'h1234);
            chk("bp_readys", {30'h0, bus.i_ready, bus.d_ready}, 32'd0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1 bus.d_rready = 1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_idle", {31'h0, bus.i_ready}, 32'd1);
        @(posedge clk); #1 bus.i_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.i_rvalid && n < 20);
        chk("bp_fetch_resp", {31'h0, bus.i_rvalid}, 32'd1);
        @(posedge clk); #1;

        // Reset during the ACCESS cycle of a store.
        exp_d_data = 32'h0; exp_d_err = 0;
        bus.d_addr = 32'h40; bus.d_wr = 1; bus.d_sz = 2'b10;
        bus.d_wdata = 32'hCAFEF00D; bus.d_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_ready && n < 20);
        @(posedge clk); #1 bus.d_valid = 0; rst_n = 0;
        @(negedge clk);
        chk("mid_access_strobe", {31'h0, bus.mem_wr}, 32'd1);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("rst2_rvalids", {30'h0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        chk("rst2_mem_wr", {31'h0, bus.mem_wr}, 32'd0);
        w0 = wr_cnt;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.d_rvalid || bus.i_rvalid) n++;
            @(negedge clk);
        end
        chk("rst2_no_resp", 32'(n), 32'd0);
        chk("rst2_no_replay", 32'(wr_cnt - w0), 32'd0);
        @(posedge clk); #1;
        req(1, 32'h20, 0, 2'b10, 0, 32'h12340000, 0, 2, wc);
        chk("rst2_idle_accept", 32'(wc), 32'd1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port byte-lane `memory` block.
- Shares one memory port between the core's instruction-fetch port (I, read-only, word) and data port (D, read/write, byte/half/word).
- Sequences every access through a latched address/data phase and a registered response.
- Rejects misaligned or illegal-size accesses with an error response; such accesses never reach memory.

Parameters:
- STARVE_MAX, 4: maximum consecutive D grants while I is pending before I is forced a grant (1..15).

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  fetch request valid
- i_ready  out  1  fetch request accepted this cycle
- i_addr  in  32  fetch byte address (word access implied)
- i_rvalid  out  1  fetch response valid
- i_rready  in  1  fetch response taken
- i_rdata  out  32  fetch read data
- i_err  out  1  fetch response is an error (valid with i_rvalid)
- d_valid  in  1  data request valid
- d_ready  out  1  data request accepted
- d_addr  in  32  data byte address
- d_wr  in  1  1 = store, 0 = load
- d_sz  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_wdata  in  32  store data, right-aligned
- d_rvalid  out  1  data response valid
- d_rready  in  1  data response taken
- d_rdata  out  32  load data, right-aligned as returned by memory
- d_err  out  1  data response is an error
- mem_addr  out  32  to memory baddr
- mem_wdata  out  32  to memory bdi
- mem_wr  out  1  to memory bwr
- mem_sz  out  2  to memory bsz
- mem_rdata  in  32  from memory bdo (combinational read)

Behaviour:
- FSM states IDLE, ACCESS, RESP. Reset (rst_n=0 at posedge) forces IDLE from any state; any in-flight access is dropped.
- Reset values: all ready/rvalid/err outputs 0, rdata 0, mem_wr 0, mem_addr 0, mem_wdata 0, mem_sz 2'b10, starvation counter 0, owner flag = I.
- IDLE arbitration (combinational, single grant):
  - D wins if d_valid, unless i_valid and the counter equals STARVE_MAX, in which case I wins.
  - I wins if only i_valid.
- IDLE handshake:
  - The winner's ready = 1 in IDLE only; the loser's ready = 0. Ready never depends on rvalid.
  - Handshake (valid & ready) latches addr, wr, sz, wdata and owner. I requests latch sz = 10 and wr = 0.
  - Counter: increments on a D grant while i_valid = 1; clears on an I grant or when i_valid = 0; saturates at STARVE_MAX.
- Alignment check, applied at handshake to the latched request. Error if any of:
  - sz = 11
  - sz = 01 and addr[0] = 1
  - sz = 10 and addr[1:0] != 00
  - An error sets err_r, skips ACCESS and goes IDLE -> RESP. mem_wr is never asserted for it.
- ACCESS, exactly 1 cycle:
  - mem_addr, mem_sz, mem_wdata driven from latched values.
  - mem_wr = wr & ~err_r.
  - rdata_r <= mem_rdata at the end of the cycle; loaded with 0 for writes.
  - Next state RESP.
- mem_* outputs hold their last value outside ACCESS; mem_wr is 1 only in ACCESS.
- RESP:
  - Owner's rvalid = 1 with rdata and err stable until rready.
  - On rready, go IDLE. No new request is accepted in the same cycle.
  - rvalid stays asserted with stable data while rready = 0.
- Latency:
  - Good access: accept in cycle N, memory strobe in N+1, rvalid in N+2; minimum 3 cycles per transaction.
  - Error access: rvalid in N+1.
- Writes to 0x80000000 (print MMIO) pass through unchanged; alignment rules apply as normal.
- Only one transaction is outstanding at a time; response ordering is trivially preserved.
- Simultaneous i_valid and d_valid with counter < STARVE_MAX: D granted; I waits with i_ready = 0.

Test Plan:
- Reset then single I fetch of addr 0x00000010 with memory word 4 = 0xDEADBEEF. Required: i_ready in cycle 1, mem_wr = 0 in cycle 2, i_rvalid = 1 with i_rdata = 0xDEADBEEF and i_err = 0 in cycle 3.
- D store: addr 0x22, sz = 01, wdata 0x1234. Required: mem_wr = 1 for exactly 1 cycle with mem_addr = 0x22 and mem_sz = 01. A following D load at 0x22, sz = 01, returns d_rdata = 0x1234.
- Misaligned requests: D word at 0x6, then D half at 0x3, then sz = 11. Required for each: d_rvalid one cycle after accept, d_err = 1, mem_wr never asserted.
- Starvation: i_valid and d_valid held high continuously with STARVE_MAX = 4. Required: grant order D, D, D, D, I, D, D, D, D, I.
- Backpressure: hold d_rready = 0 for 5 cycles in RESP. Required: d_rvalid and d_rdata stable throughout, i_ready = d_ready = 0. Release gives IDLE on the next cycle.
- Reset mid-ACCESS of a store (rst_n = 0 in cycle N+1). Required: the next cycle has all rvalid = 0, mem_wr = 0, FSM in IDLE, and the request is not replayed.
